// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-sensor front end for the vending machine controller.
// Synchronises and debounces the two raw coin sensors, turns each debounced
// rising edge into a coin code, rejects simultaneous or jammed insertions,
// and buffers accepted codes in a small FIFO drained whenever hold is low.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   coin1_in   - raw Rs.1 sensor (asynchronous)
//   coin2_in   - raw Rs.2 sensor (asynchronous)
//   hold       - downstream stall, no code issued while high
//   x          - registered coin code: 00 none, 01 Rs.1, 10 Rs.2
//   reject     - one-cycle pulse when a detected coin is discarded
//   overflow   - sticky, a coin was discarded because the FIFO was full
//   jam        - sticky, a sensor stayed high for JAM_CYCLES
//   fifo_count - current FIFO occupancy
module coin_acceptor #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 1024,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 coin1_in,
    input  logic                                 coin2_in,
    input  logic                                 hold,
    output logic [1:0]                           x,
    output logic                                 reject,
    output logic                                 overflow,
    output logic                                 jam,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned JW = $clog2(JAM_CYCLES + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    // Bit 0 is the Rs.1 channel, bit 1 the Rs.2 channel, so a single-channel
    // rise vector equals its coin code.
    logic [1:0]          meta;
    logic [1:0]          s;
    logic [1:0]          db;
    logic [1:0]          db_nxt;
    logic [1:0]          rise;
    logic [1:0][DW-1:0]  db_cnt;
    logic [1:0][DW-1:0]  db_cnt_nxt;
    logic [1:0][JW-1:0]  hi_cnt;
    logic [1:0][JW-1:0]  hi_cnt_nxt;
    logic                jam_hit;

    logic                push;
    logic                pop;
    logic                rej;
    logic                ovf_set;
    logic                full;
    logic [1:0]          code;
    logic [1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    // Two-flop synchroniser for both sensors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            s    <= '0;
        end else begin
            meta <= {coin2_in, coin1_in};
            s    <= meta;
        end
    end

    // Debounce, rising-edge detection and jam high-time counting per channel.
    always_comb begin
        db_nxt     = db;
        rise       = '0;
        db_cnt_nxt = '0;
        hi_cnt_nxt = '0;
        jam_hit    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (s[i] != db[i]) begin
                if (32'(db_cnt[i]) + 32'd1 >= DEBOUNCE_CYCLES) begin
                    db_nxt[i] = s[i];
                end else begin
                    db_cnt_nxt[i] = db_cnt[i] + DW'(1);
                end
            end
            rise[i] = db_nxt[i] & ~db[i];
            if (db[i]) begin
                // Saturate at JAM_CYCLES so a long-held sensor never wraps.
                if (32'(hi_cnt[i]) + 32'd1 >= JAM_CYCLES) begin
                    jam_hit       = 1'b1;
                    hi_cnt_nxt[i] = JW'(JAM_CYCLES);
                end else begin
                    hi_cnt_nxt[i] = hi_cnt[i] + JW'(1);
                end
            end
        end
    end

    // Event resolution and issue decision.
    always_comb begin
        full    = (fifo_count == CW'(FIFO_DEPTH));
        push    = 1'b0;
        rej     = 1'b0;
        ovf_set = 1'b0;
        code    = 2'b00;
        if (rise == 2'b11) begin
            rej = 1'b1;
        end else if (rise != 2'b00) begin
            if (jam) begin
                rej = 1'b1;
            end else if (full) begin
                // Discarded even if a pop frees a slot on this same edge.
                rej     = 1'b1;
                ovf_set = 1'b1;
            end else begin
                push = 1'b1;
                code = rise;
            end
        end
        pop = !hold && (fifo_count != '0);
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= code;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db         <= '0;
            db_cnt     <= '0;
            hi_cnt     <= '0;
            jam        <= 1'b0;
            overflow   <= 1'b0;
            reject     <= 1'b0;
            x          <= 2'b00;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            db     <= db_nxt;
            db_cnt <= db_cnt_nxt;
            hi_cnt <= hi_cnt_nxt;
            reject <= rej;
            if (jam_hit) begin
                jam <= 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            x <= pop ? mem[rd_ptr] : 2'b00;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: a vector table of single insertions
// plus hand-written sequences for latency, hold/overflow, jam and reset.
// Expected coin codes are queued when a sensor is driven and popped as the
// DUT issues codes on x.
module tb_coin_acceptor;

    localparam int D = 4;
    localparam int J = 1024;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin1_in;
    logic       coin2_in;
    logic       hold;
    logic [1:0] x;
    logic       reject;
    logic       overflow;
    logic       jam;
    logic [2:0] fifo_count;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(D),
        .JAM_CYCLES     (J),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .coin1_in  (coin1_in),
        .coin2_in  (coin2_in),
        .hold      (hold),
        .x         (x),
        .reject    (reject),
        .overflow  (overflow),
        .jam       (jam),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       c1;
        logic       c2;
        int         len;
        logic [1:0] code;
        int         rej;
    } vec_t;

    vec_t       vecs [6];
    logic [1:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rej_seen = 0;
    int codes_seen = 0;
    int first_x = -1;
    int last_x = -1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one edge, sample outputs 1ns later and score any issued code.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reject) rej_seen++;
        if (x != 2'b00) begin
            codes_seen++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            if (exp_q.size() == 0) check("x_unexpected", int'(x), 0);
            else                   check("x_code", int'(x), int'(exp_q.pop_front()));
        end
    endtask

    task automatic pulse(input logic c1, input logic c2, input int hi, input int lo);
        coin1_in = c1;
        coin2_in = c2;
        repeat (hi) tick();
        coin1_in = 1'b0;
        coin2_in = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        int c0;
        int r0;
        int n0;

        vecs[0] = '{c1: 1'b1, c2: 1'b0, len: 10, code: 2'b01, rej: 0};
        vecs[1] = '{c1: 1'b0, c2: 1'b1, len: 10, code: 2'b10, rej: 0};
        vecs[2] = '{c1: 1'b1, c2: 1'b1, len: 10, code: 2'b00, rej: 1};
        vecs[3] = '{c1: 1'b1, c2: 1'b0, len: 3,  code: 2'b00, rej: 0};
        vecs[4] = '{c1: 1'b1, c2: 1'b0, len: 4,  code: 2'b01, rej: 0};
        vecs[5] = '{c1: 1'b0, c2: 1'b1, len: 2,  code: 2'b00, rej: 0};

        reset    = 1'b0;
        coin1_in = 1'b0;
        coin2_in = 1'b0;
        hold     = 1'b0;
        #2;
        check("rst_x", int'(x), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_jam", int'(jam), 0);
        check("rst_count", int'(fifo_count), 0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();

        // Single Rs.2 coin: code appears D+2 edges after first sample.
        first_x = -1;
        c0 = cyc; r0 = rej_seen; n0 = codes_seen;
        exp_q.push_back(2'b10);
        pulse(1'b0, 1'b1, 20, 15);
        check("lat_first", first_x - c0, D + 3);
        check("lat_codes", codes_seen - n0, 1);
        check("lat_rej", rej_seen - r0, 0);
        check("lat_count", int'(fifo_count), 0);

        // Table of isolated insertions with hold low.
        for (int i = 0; i < 6; i++) begin
            r0 = rej_seen;
            if (vecs[i].code != 2'b00) exp_q.push_back(vecs[i].code);
            pulse(vecs[i].c1, vecs[i].c2, vecs[i].len, 20);
            check($sformatf("vec%0d_rej", i), rej_seen - r0, vecs[i].rej);
            check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
            check($sformatf("vec%0d_count", i), int'(fifo_count), 0);
        end

        // Hold while five Rs.1 coins arrive: four buffered, fifth overflows.
        hold = 1'b1;
        r0 = rej_seen; n0 = codes_seen;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2'b01);
            pulse(1'b1, 1'b0, 8, 12);
        end
        check("hold_count4", int'(fifo_count), 4);
        check("hold_ovf_clear", int'(overflow), 0);
        check("hold_rej_none", rej_seen - r0, 0);
        pulse(1'b1, 1'b0, 8, 12);
        check("hold_rej5", rej_seen - r0, 1);
        check("hold_ovf", int'(overflow), 1);
        check("hold_count_full", int'(fifo_count), 4);
        check("hold_no_issue", codes_seen - n0, 0);
        first_x = -1;
        c0 = cyc;
        hold = 1'b0;
        repeat (10) tick();
        check("drain_first", first_x - c0, 1);
        check("drain_span", last_x - first_x, 3);
        check("drain_codes", codes_seen - n0, 4);
        check("drain_count", int'(fifo_count), 0);
        check("drain_ovf_sticky", int'(overflow), 1);

        // Rs.1 held past the jam threshold: one code, then jam.
        n0 = codes_seen;
        exp_q.push_back(2'b01);
        coin1_in = 1'b1;
        repeat (J + 5) tick();
        check("jam_early", int'(jam), 0);
        tick();
        check("jam_set", int'(jam), 1);
        repeat (4) tick();
        coin1_in = 1'b0;
        repeat (20) tick();
        check("jam_codes", codes_seen - n0, 1);
        r0 = rej_seen;
        pulse(1'b0, 1'b1, 10, 20);
        check("jam_rej", rej_seen - r0, 1);
        check("jam_no_code", codes_seen - n0, 1);
        check("jam_sticky", int'(jam), 1);

        // Reset with two queued codes, Rs.2 held through release.
        hold = 1'b1;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        check("pre_rst_jam", int'(jam), 1);
        pulse(1'b1, 1'b0, 8, 12);
        check("pre_rst_jam_rej", int'(fifo_count), 0);
        exp_q.delete();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        pulse(1'b1, 1'b0, 8, 12);
        pulse(1'b0, 1'b1, 8, 12);
        check("pre_rst_count", int'(fifo_count), 2);
        coin2_in = 1'b1;
        reset = 1'b0;
        #1;
        check("arst_x", int'(x), 0);
        check("arst_reject", int'(reject), 0);
        check("arst_overflow", int'(overflow), 0);
        check("arst_jam", int'(jam), 0);
        check("arst_count", int'(fifo_count), 0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        hold = 1'b0;
        first_x = -1;
        c0 = cyc; n0 = codes_seen;
        exp_q.push_back(2'b10);
        repeat (20) tick();
        coin2_in = 1'b0;
        repeat (20) tick();
        check("rel_first", first_x - c0, D + 3);
        check("rel_codes", codes_seen - n0, 1);
        check("rel_pending", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage for the vending machine controller: it turns the two raw coin-sensor lines into the 2-bit coin code `x` that the controller consumes (00 none, 01 Rs.1, 10 Rs.2). It synchronises and debounces each sensor, detects one coin per debounced rising edge, and rejects ambiguous or jammed insertions. Accepted coins are buffered in a small FIFO so coins arriving while the controller signals `hold` are not lost.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced level changes; must be ≥1.
- `JAM_CYCLES`, default 1024: consecutive cycles a debounced level may stay high before a jam is declared; must be greater than `DEBOUNCE_CYCLES`.
- `FIFO_DEPTH`, default 4: coin-code buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `coin1_in` in 1: raw Rs.1 sensor, asynchronous, high while a coin passes.
- `coin2_in` in 1: raw Rs.2 sensor, asynchronous, high while a coin passes.
- `hold` in 1: downstream stall; while high, no code is issued on `x`.
- `x` out 2: registered coin code to the controller; 01 or 10 for exactly one cycle per coin, otherwise 00.
- `reject` out 1: registered one-cycle pulse when a detected coin is discarded.
- `overflow` out 1: sticky; set when a coin is discarded because the FIFO is full.
- `jam` out 1: sticky; set on jam detection.
- `fifo_count` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation
- Reset (`reset`=0): sync flops, debounced levels, and counters cleared; FIFO emptied; `x`=00, `reject`=0, `overflow`=0, `jam`=0, `fifo_count`=0.
- Synchroniser: each sensor passes through 2 flops to produce `s1`/`s2`.
- Debounce, per channel: counter increments each cycle `sN` ≠ `dbN` and clears when they are equal. When the counter would reach `DEBOUNCE_CYCLES`, `dbN` takes `sN` and the counter clears. Glitches shorter than `DEBOUNCE_CYCLES` cycles have no effect.
- Coin event: `dbN` transitions 0→1 (edge `rN`, computed on the same edge that `dbN` updates).
- Event resolution, evaluated on the same edge:
  - `r1` and `r2` together: nothing is pushed and `reject` pulses.
  - Single event while `jam`=1: nothing is pushed and `reject` pulses.
  - Single event while the FIFO is full: nothing is pushed, `reject` pulses, and `overflow` is set.
  - Otherwise the code (01 for channel 1, 10 for channel 2) is pushed.
- Jam: a per-channel high-time counter runs while `dbN`=1 and clears when `dbN`=0. When it reaches `JAM_CYCLES`, `jam` is set. `jam` blocks further pushes but not draining of the FIFO. Only reset clears `jam` and `overflow`.
- Issue: on each edge, if `hold`=0 and the FIFO is non-empty, `x` takes the head code and the entry is popped; otherwise `x` takes 00. Back-to-back codes on consecutive cycles are allowed.
- Push and pop on the same edge: both take effect and `fifo_count` is unchanged. A push into a full FIFO is still discarded even if a pop occurs on that edge.
- Width rules: counters saturate rather than wrap. The FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

## Timing
- If raw `coinN_in` is first sampled high at edge k and stays high, `sN` rises at edge k+1, and `dbN` rises and the push occurs at edge k+1+D (D=`DEBOUNCE_CYCLES`).
- `x` shows the code after edge k+2+D when the FIFO was empty and `hold`=0: latency D+2 cycles, 6 cycles with the default D.
- `hold` is sampled on the issuing edge: `hold` high at edge e means `x`=00 after e. The first code appears one edge after `hold` falls.
- `reject` and `overflow` assert after the same edge the push would have occurred on.
- `jam` is set after edge k+1+D+`JAM_CYCLES`.
- Reset deasserted while a raw sensor is held high: the level is debounced from zero and counts as a new coin after D+2 cycles.
- Reset asserted mid-operation: FIFO contents are lost, and `x` drops to 00 asynchronously.

## Test plan
- Single Rs.2 coin, D=4, `coin2_in` high 20 cycles from edge 0 → `x`=10 for exactly one cycle after edge 6; `fifo_count` returns to 0; no `reject`.
- `coin1_in` glitch of 3 cycles, then a clean 10-cycle pulse → exactly one `x`=01; the glitch produces no event.
- Both sensors rise together for 10 cycles → one `reject` pulse, `x` stays 00, `fifo_count`=0.
- `hold`=1 while 5 Rs.1 coins are inserted, FIFO_DEPTH=4 → `fifo_count`=4, 5th coin gives `reject` pulse and `overflow`=1. Releasing `hold` yields four consecutive cycles of `x`=01.
- `coin1_in` held high for `JAM_CYCLES`+10 cycles → one `x`=01, then `jam`=1. A later clean Rs.2 coin gives `reject` with no code; `jam` clears only on reset.
- Reset asserted for 1 cycle with 2 queued codes and `hold`=1 → all outputs 0 immediately. `coin2_in` kept high through reset release gives `x`=10 after D+2 cycles.
